hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Parametrised hazard/flush controller for the 5-stage pipeline. It is the successor to the branch-only flush unit and adds:
- load-use and (optionally) non-forwarded RAW stall detection
- multi-cycle branch flush
- memory-wait freeze
- halt/createdump drain sequencing
- saturating stall/flush performance counters

It drives PC/FD write enables and per-stage NOP injection for the FD, DE, EM and MW pipeline registers.

Parameters:
REG_AW, 3, register-specifier width.
FWD_EN, 1, 1 = EX/MEM forwarding exists (only load-use stalls); 0 = any pending writer in DE or EM to a source register stalls.
FLUSH_DEPTH, 1, cycles of FD bubble after a taken branch/jump (legal 1..4).
DRAIN_CYCLES, 3, cycles after halt entry until the pipeline is considered empty (legal 1..7).
CNT_W, 16, performance counter width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-low reset.
PCSrc  in  2  PC select from EX; PCSrc[1]=1 means branch/jump taken.
stall  in  1  halt/createdump decoded in ID.
mem_busy  in  1  data memory not ready; freezes the whole pipeline.
ID_rs, ID_rt  in  REG_AW each  ID source specifiers.
ID_rs_valid, ID_rt_valid  in  1 each  the source is actually read.
DE_rd  in  REG_AW  destination in DE.
DE_regwrite, DE_memread  in  1 each.
EM_rd  in  REG_AW  destination in EM.
EM_regwrite  in  1.
PC_en  out  1  PC write enable.
FD_en  out  1  FD register enable (0 = recycle).
pipe_en  out  1  DE/EM/MW register enable.
FD_NOP, DE_NOP, EM_NOP, MW_NOP  out  1 each  load bubble into that register.
halted  out  1  halt drained.
state  out  2  FSM state: RUN=0, FLUSH=1, HALT=2.
stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
General
- State and counters are registered. All other outputs are combinational from the registered state and the current inputs.
- All register updates occur at posedge clk.

Reset
- rst=0 sampled at posedge: state=RUN, flush counter=0, drain counter=0, stall_cnt=0, flush_cnt=0.
- While rst=0: PC_en=0, FD_en=0, pipe_en=1, all four NOPs=1, halted=0.
- Reset mid-flush or mid-halt aborts the sequence immediately.

Hazard terms
- br = PCSrc[1].
- ld_use = DE_memread & DE_regwrite & (rs_match_DE | rt_match_DE).
  - rs_match_X = ID_rs_valid & (ID_rs==X_rd); rt_match_X likewise for ID_rt.
- FWD_EN=0: raw = ld_use | (DE_regwrite & match_DE) | (EM_regwrite & match_EM).
- FWD_EN=1: raw = ld_use.

Priority (highest first): reset > mem_busy > br > stall > raw.

Freeze
- mem_busy=1 in any state: PC_en=0, FD_en=0, pipe_en=0, all NOPs=0.
- State, flush counter, drain counter and perf counters all hold.

RUN
- br: PC_en=1, FD_en=1, FD_NOP=1, DE_NOP=1.
  - If FLUSH_DEPTH>1, go to FLUSH with flush counter=FLUSH_DEPTH-1.
  - flush_cnt +1.
  - Any simultaneous stall or raw is ignored (wrong path).
- else stall: PC_en=0, FD_en=0, DE_NOP=0, go to HALT with drain counter=DRAIN_CYCLES.
- else raw: PC_en=0, FD_en=0, DE_NOP=1, stall_cnt +1. Re-evaluated every cycle; no stored stall state.
- else: PC_en=1, FD_en=1, pipe_en=1, all NOPs=0.

FLUSH
- Each cycle: FD_NOP=1, PC_en=1, FD_en=1, flush_cnt +1, flush counter -1.
- Go to RUN when the counter reaches 0 in that cycle.
- stall and raw are ignored (ID holds a bubble).
- br in FLUSH: flush counter reloads to FLUSH_DEPTH-1, DE_NOP=1 also.

HALT
- PC_en=0, FD_en=0, FD_NOP=1, DE_NOP=1.
- Drain counter decrements to 0 and then holds.
- halted=1 when the drain counter is 0; EM_NOP=MW_NOP=1 from then on.
- HALT exits only through reset. Inputs other than rst and mem_busy are ignored.

Illegal state (3): go to RUN next cycle, outputs as RUN.

Counters
- Saturate at 2^CNT_W-1; no wrap.
- Frozen cycles are not counted.

Test Plan:
1. Load-use: rst released; DE_memread=1, DE_regwrite=1, DE_rd=3, ID_rs=3, ID_rs_valid=1 for 1 cycle -> that cycle PC_en=0, FD_en=0, DE_NOP=1, stall_cnt=1. Next cycle with no hazard -> all enables 1.
2. Taken branch, FLUSH_DEPTH=3: PCSrc=2'b10 with a simultaneous load-use -> FD_NOP=DE_NOP=1, PC_en=1, stall_cnt unchanged; then FD_NOP=1 for 2 more cycles, state=RUN on the 4th cycle, flush_cnt=3.
3. FWD_EN=0: EM_regwrite=1, EM_rd=5, ID_rt=5, ID_rt_valid=1 -> stall asserted. Same stimulus with FWD_EN=1 -> no stall.
4. Halt: stall=1 -> state=HALT; halted rises exactly DRAIN_CYCLES=3 cycles later with EM_NOP=MW_NOP=1. A later PCSrc=2'b11 has no effect. rst=0 -> state=RUN.
5. Freeze: mem_busy=1 for 4 cycles during FLUSH -> pipe_en=0, counters and state unchanged. Flush resumes where it stopped after mem_busy drops.
6. Saturation/reset: CNT_W=4, 20 raw cycles -> stall_cnt holds 15. Assert rst mid-FLUSH -> all NOPs=1, counters 0 at the next edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/flush controller for the 5-stage pipeline: load-use/RAW stalls, multi-cycle
// branch flush, memory-wait freeze, halt drain sequencing and saturating perf counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW       = 3,
  parameter int unsigned FWD_EN       = 1,
  parameter int unsigned FLUSH_DEPTH  = 1,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        PCSrc,
  input  logic              stall,
  input  logic              mem_busy,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic              ID_rs_valid,
  input  logic              ID_rt_valid,
  input  logic [REG_AW-1:0] DE_rd,
  input  logic              DE_regwrite,
  input  logic              DE_memread,
  input  logic [REG_AW-1:0] EM_rd,
  input  logic              EM_regwrite,
  output logic              PC_en,
  output logic              FD_en,
  output logic              pipe_en,
  output logic              FD_NOP,
  output logic              DE_NOP,
  output logic              EM_NOP,
  output logic              MW_NOP,
  output logic              halted,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FLUSH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_DEPTH - 1);
  localparam logic [2:0] DRAIN_LOAD   = 3'(DRAIN_CYCLES);

  logic [1:0]       r_state, w_state_d;
  logic [2:0]       r_fcnt, w_fcnt_d;
  logic [2:0]       r_dcnt, w_dcnt_d;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_stall_inc, w_flush_inc;

  logic w_br, w_ld_use, w_raw;
  logic w_rs_de, w_rt_de, w_rs_em, w_rt_em;
  logic w_unused_pcsrc;

  assign w_unused_pcsrc = PCSrc[0];
  assign w_br    = PCSrc[1];
  assign w_rs_de = ID_rs_valid & (ID_rs == DE_rd);
  assign w_rt_de = ID_rt_valid & (ID_rt == DE_rd);
  assign w_rs_em = ID_rs_valid & (ID_rs == EM_rd);
  assign w_rt_em = ID_rt_valid & (ID_rt == EM_rd);

  assign w_ld_use = DE_memread & DE_regwrite & (w_rs_de | w_rt_de);
  assign w_raw    = (FWD_EN != 0) ? w_ld_use
                  : (w_ld_use | (DE_regwrite & (w_rs_de | w_rt_de))
                              | (EM_regwrite & (w_rs_em | w_rt_em)));

  always_comb begin
    w_state_d   = r_state;
    w_fcnt_d    = r_fcnt;
    w_dcnt_d    = r_dcnt;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    PC_en       = 1'b1;
    FD_en       = 1'b1;
    pipe_en     = 1'b1;
    FD_NOP      = 1'b0;
    DE_NOP      = 1'b0;
    EM_NOP      = 1'b0;
    MW_NOP      = 1'b0;
    halted      = (r_state == ST_HALT) && (r_dcnt == 3'd0);

    if (!rst) begin
      PC_en  = 1'b0;
      FD_en  = 1'b0;
      FD_NOP = 1'b1;
      DE_NOP = 1'b1;
      EM_NOP = 1'b1;
      MW_NOP = 1'b1;
      halted = 1'b0;
    end else if (mem_busy) begin
      PC_en   = 1'b0;
      FD_en   = 1'b0;
      pipe_en = 1'b0;
    end else begin
      case (r_state)
        ST_FLUSH: begin
          FD_NOP      = 1'b1;
          w_flush_inc = 1'b1;
          if (w_br) begin
            DE_NOP   = 1'b1;
            w_fcnt_d = FLUSH_RELOAD;
          end else begin
            w_fcnt_d = r_fcnt - 3'd1;
          end
          if (w_fcnt_d == 3'd0) w_state_d = ST_RUN;
        end
        ST_HALT: begin
          PC_en  = 1'b0;
          FD_en  = 1'b0;
          FD_NOP = 1'b1;
          DE_NOP = 1'b1;
          if (r_dcnt != 3'd0) w_dcnt_d = r_dcnt - 3'd1;
          if (halted) begin
            EM_NOP = 1'b1;
            MW_NOP = 1'b1;
          end
        end
        default: begin
          // RUN; the illegal encoding decodes identically but always returns to RUN.
          w_state_d = ST_RUN;
          if (w_br) begin
            FD_NOP      = 1'b1;
            DE_NOP      = 1'b1;
            w_flush_inc = 1'b1;
            if (FLUSH_DEPTH > 1 && r_state == ST_RUN) begin
              w_state_d = ST_FLUSH;
              w_fcnt_d  = FLUSH_RELOAD;
            end
          end else if (stall) begin
            PC_en = 1'b0;
            FD_en = 1'b0;
            if (r_state == ST_RUN) begin
              w_state_d = ST_HALT;
              w_dcnt_d  = DRAIN_LOAD;
            end
          end else if (w_raw) begin
            PC_en       = 1'b0;
            FD_en       = 1'b0;
            DE_NOP      = 1'b1;
            w_stall_inc = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_RUN;
      r_fcnt      <= 3'd0;
      r_dcnt      <= 3'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_d;
      r_fcnt  <= w_fcnt_d;
      r_dcnt  <= w_dcnt_d;
      if (w_stall_inc && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush_inc && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
